// File: rtl/tmr_scrubber.sv
// Read-back voter and repair controller for a triplicated register bank.
// Owns the bank's shared load interface: user writes and scrub write-backs.
module tmr_scrubber #(
  parameter int dw        = 8,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 16
) (
  input  logic             c,
  input  logic             r,
  input  logic             en,
  input  logic             clr,
  input  logic [dw-1:0]    q1,
  input  logic [dw-1:0]    q2,
  input  logic [dw-1:0]    q3,
  input  logic             wr_en,
  input  logic [dw-1:0]    wr_data,
  output logic [dw-1:0]    d,
  output logic             e,
  output logic [dw-1:0]    q,
  output logic             err_now,
  output logic [2:0]       bad,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fault,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    MON    = 3'd0,
    SETTLE = 3'd1,
    SCRUB  = 3'd2,
    VERIFY = 3'd3,
    FLT    = 3'd4
  } state_t;

  // Handshake: the bank loads d into all three copies on the edge that ends
  // a cycle with e=1; the copies show that value from the following cycle.
  state_t           state, nxt, cur;
  logic [RW-1:0]    retry, nxt_retry;
  logic [dw-1:0]    nxt_d;
  logic             nxt_e, nxt_fault, fault_b;
  logic [2:0]       nxt_bad, bad_b;
  logic [CNT_W-1:0] nxt_cnt, cnt_b;

  assign q         = (q1 & q2) | (q1 & q3) | (q2 & q3);
  assign err_now   = |((q1 ^ q2) | (q1 ^ q3));
  assign dbg_state = state;

  always_comb begin
    // clr acts as an immediate return to an empty MON, so a same-cycle
    // write or detection is handled as if the clear had already happened.
    cur       = clr ? MON : state;
    cnt_b     = clr ? '0 : err_cnt;
    bad_b     = clr ? 3'b000 : bad;
    fault_b   = clr ? 1'b0 : fault;
    nxt       = cur;
    nxt_d     = d;
    nxt_e     = 1'b0;
    nxt_bad   = bad_b;
    nxt_cnt   = cnt_b;
    nxt_fault = fault_b;
    nxt_retry = clr ? '0 : retry;
    if (wr_en) begin
      nxt_e     = 1'b1;
      nxt_d     = wr_data;
      nxt_retry = '0;
      nxt       = (cur == FLT) ? FLT : SETTLE;
    end else begin
      case (cur)
        MON: begin
          if (en && err_now && !fault_b) begin
            nxt_e     = 1'b1;
            nxt_d     = q;
            nxt_bad   = {q3 != q, q2 != q, q1 != q};
            nxt_cnt   = (cnt_b == '1) ? cnt_b : cnt_b + CNT_W'(1);
            nxt_retry = RW'(1);
            nxt       = SCRUB;
          end
        end
        SETTLE: nxt = MON;
        SCRUB:  nxt = VERIFY;
        VERIFY: begin
          if (!err_now) begin
            nxt_retry = '0;
            nxt       = MON;
          end else if (retry < RW'(MAX_RETRY)) begin
            nxt_e     = 1'b1;
            nxt_d     = q;
            nxt_retry = retry + RW'(1);
            nxt       = SCRUB;
          end else begin
            nxt_fault = 1'b1;
            nxt       = FLT;
          end
        end
        FLT:     nxt = FLT;
        default: nxt = MON;
      endcase
    end
  end

  always_ff @(posedge c) begin
    if (r) begin
      state   <= MON;
      d       <= '0;
      e       <= 1'b0;
      bad     <= 3'b000;
      err_cnt <= '0;
      fault   <= 1'b0;
      busy    <= 1'b0;
      retry   <= '0;
    end else begin
      state   <= nxt;
      d       <= nxt_d;
      e       <= nxt_e;
      bad     <= nxt_bad;
      err_cnt <= nxt_cnt;
      fault   <= nxt_fault;
      busy    <= (nxt != MON);
      retry   <= nxt_retry;
    end
  end

endmodule

// File: tb/tb_tmr_scrubber.sv
// Directed bench for tmr_scrubber: a behavioural triplicated bank with
// read-upset injection and a stuck copy closes the load loop.
module tb_tmr_scrubber;

  logic       c = 1'b0;
  logic       r, en, clr, wr_en;
  logic [7:0] wr_data, q1, q2, q3;
  logic [7:0] d, q;
  logic       e, err_now, fault, busy;
  logic [2:0] bad, dbg_state;
  logic [15:0] err_cnt;
  logic [7:0] s_d, s_q;
  logic       s_e, s_err_now, s_fault, s_busy;
  logic [2:0] s_bad, s_dbg_state;
  logic [3:0] s_err_cnt;

  logic [7:0] b1 = 8'h00, b2 = 8'h00, b3 = 8'h00;
  logic [7:0] inj1, inj2, inj3, v1, v2, v3;
  logic       ovr, stk3;

  int n_vec = 0;
  int n_miss = 0;
  int pulses;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] a, b, cc, exp_vote;
    logic       exp_err;
  } vote_vec_t;
  vote_vec_t vt[7];

  always #5 c = ~c;

  tmr_scrubber #(.dw(8), .MAX_RETRY(2), .CNT_W(16)) dut (
    .c(c), .r(r), .en(en), .clr(clr), .q1(q1), .q2(q2), .q3(q3),
    .wr_en(wr_en), .wr_data(wr_data), .d(d), .e(e), .q(q), .err_now(err_now),
    .bad(bad), .err_cnt(err_cnt), .fault(fault), .busy(busy), .dbg_state(dbg_state)
  );

  tmr_scrubber #(.dw(8), .MAX_RETRY(2), .CNT_W(4)) sat (
    .c(c), .r(r), .en(en), .clr(clr), .q1(q1), .q2(q2), .q3(q3),
    .wr_en(wr_en), .wr_data(wr_data), .d(s_d), .e(s_e), .q(s_q), .err_now(s_err_now),
    .bad(s_bad), .err_cnt(s_err_cnt), .fault(s_fault), .busy(s_busy), .dbg_state(s_dbg_state)
  );

  always @(posedge c) if (e) begin
    b1 <= d;
    b2 <= d;
    b3 <= d;
  end

  assign q1 = ovr ? v1 : (b1 ^ inj1);
  assign q2 = ovr ? v2 : (b2 ^ inj2);
  assign q3 = ovr ? v3 : (stk3 ? 8'hFF : (b3 ^ inj3));

  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vt[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[1] = '{8'h5A, 8'h5B, 8'h5A, 8'h5A, 1'b1};
    vt[2] = '{8'hFF, 8'h00, 8'h0F, 8'h0F, 1'b1};
    vt[3] = '{8'hAA, 8'h55, 8'hFF, 8'hFF, 1'b1};
    vt[4] = '{8'hF0, 8'hF0, 8'h0F, 8'hF0, 1'b1};
    vt[5] = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b0};
    vt[6] = '{8'h81, 8'h18, 8'h42, 8'h00, 1'b1};

    r = 1'b1; en = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    ovr = 1'b0; stk3 = 1'b0; inj1 = 8'h00; inj2 = 8'h00; inj3 = 8'h00;
    v1 = 8'h00; v2 = 8'h00; v3 = 8'h00;

    // reset state
    step();
    r = 1'b0;
    chk("rst_e", e, 0); chk("rst_d", d, 0); chk("rst_bad", bad, 0);
    chk("rst_cnt", err_cnt, 0); chk("rst_fault", fault, 0); chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0); chk("rst_sat_cnt", s_err_cnt, 0);

    // combinational vote table
    ovr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      v1 = vt[i].a; v2 = vt[i].b; v3 = vt[i].cc;
      #1;
      chk($sformatf("vote_q[%0d]", i), q, vt[i].exp_vote);
      chk($sformatf("vote_err[%0d]", i), err_now, vt[i].exp_err);
    end
    ovr = 1'b0;

    // load bank, then quiet monitoring
    wr_en = 1'b1; wr_data = 8'h5A;
    step();
    wr_en = 1'b0;
    chk("wr_e", e, 1); chk("wr_d", d, 8'h5A); chk("wr_busy", busy, 1);
    step();
    chk("settle_e", e, 0); chk("settle_busy", busy, 0);
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("quiet_e", e, 0); chk("quiet_cnt", err_cnt, 0); chk("quiet_bad", bad, 0);
      chk("quiet_q", q, 8'h5A); chk("quiet_busy", busy, 0);
    end

    // single read upset on copy 2; en drops mid-repair
    inj2 = 8'h01;
    step();
    inj2 = 8'h00; en = 1'b0;
    chk("ups_e", e, 1); chk("ups_d", d, 8'h5A); chk("ups_bad", bad, 3'b010);
    chk("ups_cnt", err_cnt, 1); chk("ups_busy", busy, 1);
    step();
    chk("ups_drop_e", e, 0); chk("ups_verify_busy", busy, 1);
    step();
    chk("ups_mon_busy", busy, 0); chk("ups_mon_e", e, 0); chk("ups_err_now", err_now, 0);
    chk("ups_q", q, 8'h5A);
    en = 1'b1;

    // write collides with mismatch; mismatch persists through SETTLE
    inj2 = 8'h01; wr_en = 1'b1; wr_data = 8'h33;
    step();
    wr_en = 1'b0;
    chk("col_e", e, 1); chk("col_d", d, 8'h33); chk("col_cnt", err_cnt, 1);
    chk("col_bad", bad, 3'b010); chk("col_busy", busy, 1);
    step();
    inj2 = 8'h00;
    chk("col_settle_e", e, 0); chk("col_settle_cnt", err_cnt, 1);
    chk("col_settle_busy", busy, 0); chk("col_q", q, 8'h33);
    step();
    chk("col_after_e", e, 0); chk("col_after_busy", busy, 0); chk("col_after_cnt", err_cnt, 1);

    // clear, reload 0x00, then copy 3 stuck at 0xFF
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_cnt", err_cnt, 0); chk("clr_bad", bad, 0);
    wr_en = 1'b1; wr_data = 8'h00;
    step();
    wr_en = 1'b0;
    step();
    chk("stk_pre_q", q, 8'h00);
    stk3 = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (e) begin
        pulses++;
        if (exp_q.size() > 0) chk("stk_scrub_d", d, exp_q.pop_front());
        else begin
          n_vec++; n_miss++;
          $display("FAIL stk_extra_pulse: got e=1 d=%0h expected no pulse", d);
        end
      end
    end
    chk("stk_pulses", pulses, 2); chk("stk_queue_left", exp_q.size(), 0);
    chk("stk_fault", fault, 1); chk("stk_bad", bad, 3'b100);
    chk("stk_cnt", err_cnt, 1); chk("stk_busy", busy, 1);
    wr_en = 1'b1; wr_data = 8'h11;
    step();
    wr_en = 1'b0;
    chk("flt_wr_e", e, 1); chk("flt_wr_d", d, 8'h11); chk("flt_wr_fault", fault, 1);
    step();
    chk("flt_idle_e", e, 0); chk("flt_idle_fault", fault, 1); chk("flt_err_now", err_now, 1);
    chk("flt_q", q, 8'h11);
    en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("flt_clr_fault", fault, 0); chk("flt_clr_cnt", err_cnt, 0);
    chk("flt_clr_bad", bad, 0); chk("flt_clr_busy", busy, 0);
    // clear with a live detection counts it once
    err_cnt_bump();

    // saturation on the 4-bit counter instance
    en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      inj1 = 8'h80;
      step();
      inj1 = 8'h00;
      chk("sat_main_cnt", err_cnt, k);
      chk("sat_small_cnt", s_err_cnt, (k > 15) ? 15 : k);
      chk("sat_e", e, 1);
      step();
      step();
      chk("sat_mon_busy", busy, 0);
    end

    // reset while SCRUB presents e
    inj2 = 8'h02;
    step();
    inj2 = 8'h00;
    chk("mid_scrub_e", e, 1); chk("mid_scrub_busy", busy, 1);
    r = 1'b1;
    step();
    r = 1'b0;
    chk("mid_rst_e", e, 0); chk("mid_rst_busy", busy, 0); chk("mid_rst_cnt", err_cnt, 0);
    chk("mid_rst_bad", bad, 0); chk("mid_rst_fault", fault, 0); chk("mid_rst_sat_cnt", s_err_cnt, 0);
    step();
    chk("post_rst_e", e, 0); chk("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  task automatic err_cnt_bump();
    clr = 1'b1; en = 1'b1;
    step();
    clr = 1'b0; en = 1'b0;
    chk("clr_det_cnt", err_cnt, 1); chk("clr_det_bad", bad, 3'b100);
    chk("clr_det_e", e, 1); chk("clr_det_d", d, 8'h11); chk("clr_det_busy", busy, 1);
    stk3 = 1'b0;
    step();
    step();
    chk("clr_det_done_busy", busy, 0); chk("clr_det_done_fault", fault, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_det_zero", err_cnt, 0);
  endtask

endmodule

// File: doc/tmr_scrubber.md
Name: tmr_scrubber

Overview:
- Read-back and repair side of a triplicated register bank with separate copy outputs and a shared load enable.
- Samples the three copies every cycle and votes them.
- On copy disagreement, writes the voted value back through the bank's data/enable inputs, then checks that the repair took.
- Counts upset events, reports which copy is bad, and raises a sticky fault after repeated failed repairs.
- Also muxes in the user write path so one block owns the bank's load interface.

Parameters:
- dw, 8, width of the protected register
- MAX_RETRY, 2, scrub attempts per event before declaring fault (>=1)
- CNT_W, 16, width of saturating upset counter

Ports:
- c  in  1  clock
- r  in  1  reset; synchronous, active-high
- en  in  1  scrub enable; 0 = detect/report only
- clr  in  1  synchronous clear of fault, err_cnt, bad
- q1  in  dw  copy 1 from bank
- q2  in  dw  copy 2 from bank
- q3  in  dw  copy 3 from bank
- wr_en  in  1  user write request, single cycle
- wr_data  in  dw  user write value
- d  out  dw  registered data to bank; drives all three copy inputs
- e  out  1  registered load enable to bank
- q  out  dw  combinational bitwise majority of q1/q2/q3
- err_now  out  1  combinational; any bit of any copy differs
- bad  out  3  registered mask; bit i set if copy i+1 differed from vote at last detection
- err_cnt  out  CNT_W  registered saturating count of detected upset events
- fault  out  1  registered sticky; repair failed MAX_RETRY times
- busy  out  1  registered; state is not MON

Behaviour:
- Reset (r high at a rising edge of c): after that edge the state is MON, d=0, e=0, bad=0, err_cnt=0, fault=0, busy=0, and the retry counter is 0. Reset overrides all other inputs, including mid-scrub; any e pulse in flight is dropped.
- Vote: q = (q1&q2)|(q1&q3)|(q2&q3). err_now = |((q1^q2)|(q1^q3)).
- Bank timing: e/d registered here. The bank captures on the edge ending the cycle e=1, so copies reflect the write one cycle after e is high.
- States:
  - MON:
    - wr_en=1: next cycle e=1, d=wr_data; go SETTLE. User write has priority over a mismatch seen in the same cycle; no count and no bad update for that cycle.
    - else en=1, err_now=1, fault=0: next cycle e=1, d=q (voted value); bad updated from this cycle's copies; err_cnt+1 (saturating at all-ones); retry=1; go SCRUB.
    - else: e=0.
  - SETTLE: one cycle; e=0; mismatch ignored (copies still old); go MON. wr_en here behaves as in MON (a new write, re-enter SETTLE).
  - SCRUB: the cycle e=1 is presented; e drops next cycle; go VERIFY. wr_en here aborts the repair: write issued, go SETTLE, no fault.
  - VERIFY: copies now reflect the scrub write.
    - wr_en: same as MON (write, go SETTLE).
    - err_now=0: go MON, retry=0.
    - err_now=1 and retry<MAX_RETRY: re-issue e=1 with d=q, retry+1, go SCRUB. err_cnt is not incremented on retries.
    - err_now=1 and retry=MAX_RETRY: fault=1, go FAULT.
  - FAULT: no scrubbing. User writes still pass (e=1, d=wr_data the next cycle; state stays FAULT). err_now/q remain live. Exit only via clr or r.
- clr: err_cnt=0, bad=0, fault=0, state MON. Same-cycle wr_en is still issued and goes to SETTLE. A same-cycle detection is counted as 1 after the clear.
- en=0 while in SCRUB/VERIFY: the in-progress repair completes; no new event starts in MON.
- e is never high two consecutive cycles except back-to-back user writes.

Test Plan:
- r=1 then q1=q2=q3=0x5A, en=1 for 20 cycles -> e=0 throughout, err_cnt=0, bad=000, q=0x5A, busy=0.
- q2 forced to 0x5B for one cycle, bench bank model honours e -> next cycle e=1, d=0x5A, bad=010, err_cnt=1; two cycles later copies agree and the block is in MON.
- q1=q2=0x00, q3 stuck at 0xFF, MAX_RETRY=2 -> exactly two e pulses with d=0x00, then fault=1, bad=100, err_cnt=1; a later wr_en 0x11 still gives e=1, d=0x11; clr -> fault=0, err_cnt=0.
- Mismatch and wr_en=1 with wr_data=0x33 in the same MON cycle -> e=1, d=0x33, err_cnt unchanged, SETTLE for one cycle, no scrub afterward once copies read 0x33.
- CNT_W=4, 20 separate single-copy upsets -> err_cnt stops at 15, no wrap.
- r=1 on the cycle SCRUB presents e=1 -> after the edge e=0, busy=0, err_cnt=0, bad=000, fault=0.
